rca_seq_ctrl: RTL and testbench
===============================

Name: rca_seq_ctrl

Overview:
- Multi-precision adder sequencer.
- Accepts one wide operand pair (chunkWidth*numChunks bits) over a valid/ready handshake.
- Time-multiplexes a single chunkWidth-bit RCA instance, one chunk per cycle from LSB to MSB, and registers the carry between cycles.
- Returns the wide sum and carry-out over a second valid/ready handshake.
- Sits between arithmetic-unit issue logic and the shared narrow adder, trading latency for area.

Parameters:
- chunkWidth, 32, width of the internal RCA instance (bits per cycle), >=1.
- numChunks, 4, number of chunks per operation, >=2; total width W = chunkWidth*numChunks.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block can accept an operation.
- a  input  W  operand A, sampled on input handshake.
- b  input  W  operand B, sampled on input handshake.
- ci  input  1  carry-in to chunk 0, sampled on input handshake.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- s  output  W  sum, stable while out_valid=1.
- co  output  1  carry-out of MSB chunk, stable while out_valid=1.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state<=IDLE, chunk counter<=0, carry reg<=0.
  - Operand/result regs <=0.
  - in_ready=1, out_valid=0, s=0, co=0, busy=0 from the next cycle.
  - Reset mid-operation discards the operation silently; no output is produced.
- States: IDLE, RUN, DONE; encoding is free.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b, ci into the operand/carry regs, cnt<=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, the RCA adds chunk cnt of the A reg and B reg with the carry reg.
  - Its sum is written to result chunk cnt; its co is written to the carry reg.
  - cnt increments.
  - When cnt==numChunks-1: go to DONE; co<=RCA co.
- DONE:
  - out_valid=1, in_ready=0.
  - On out_ready=1: go to IDLE, out_valid deasserts next cycle.
  - On out_ready=0: hold s/co/out_valid unchanged indefinitely.
- Latency: input handshake at edge E0 -> out_valid=1 in the cycle after edge E0+numChunks (numChunks RUN cycles). Throughput is one op per numChunks+2 cycles minimum (IDLE re-entry included). No back-to-back accept in DONE.
- Arithmetic is unsigned modulo 2^W; {co,s} == a+b+ci exactly.
- Counter is $clog2(numChunks) bits wide; no wrap occurs because RUN exits at numChunks-1.
- in_valid while in_ready=0 is ignored; the source must hold it. a/b changes outside the handshake have no effect.
- The s register may be partially updated during RUN. The consumer only samples s when out_valid=1.
- rst has priority over every handshake in the same cycle.

Optional Feature:
- Macro: RCA_SEQ_SUB_EN.
- Defined:
  - Adds port sub (input, 1), sampled with the operands on the input handshake.
  - When sub=1: B reg latches ~b and the carry reg latches 1 (ci ignored), so s = a-b mod 2^W and co = 1 iff a>=b (no borrow).
  - When sub=0: behaviour is identical to undefined.
- Undefined: no sub port; add-only.

Test Plan:
- Defaults, a=0x1, b=0xFFFF_FFFF (W=128), ci=0 -> after 4 RUN cycles s=0x1_0000_0000, co=0; carry propagates chunk0->chunk1.
- a=b=all-ones (128b), ci=1 -> s=all-ones, co=1; out_valid exactly in the cycle after edge E0+4.
- out_ready held 0 for 10 cycles in DONE -> s/co/out_valid constant; in_ready=0; a second in_valid is not accepted. Then out_ready=1 -> IDLE, in_ready=1 next cycle.
- rst asserted in 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, s=0. A new op (a=5, b=7, ci=0) then yields s=12, co=0.
- Back-to-back: 100 random ops with random in_valid/out_ready stalls, checked against a golden a+b+ci model -> zero mismatches, no dropped or duplicated results.
- RCA_SEQ_SUB_EN: sub=1, a=3, b=5 -> s=2^128-2, co=0. sub=1, a=5, b=3 -> s=2, co=1.

Source files
------------

// File: rtl/rca_seq_ctrl.sv
// Multi-precision adder sequencer: one chunkWidth-bit ripple-carry adder reused over numChunks cycles, LSB first.
// Optional macro RCA_SEQ_SUB_EN adds a 'sub' port so the same datapath computes a-b.
module rca_seq_ctrl #(
  parameter int chunkWidth = 32,
  parameter int numChunks  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [chunkWidth*numChunks-1:0]  a,
  input  logic [chunkWidth*numChunks-1:0]  b,
  input  logic                             ci,
`ifdef RCA_SEQ_SUB_EN
  input  logic                             sub,
`endif
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [chunkWidth*numChunks-1:0]  s,
  output logic                             co,
  output logic                             busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid must be held until that edge, and ready depends only on the FSM state.
  localparam int W     = chunkWidth * numChunks;
  localparam int CNT_W = $clog2(numChunks);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(numChunks - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  carry_q, carry_d;
  logic                  co_q, co_d;
  logic [chunkWidth-1:0] a_q   [numChunks];
  logic [chunkWidth-1:0] a_d   [numChunks];
  logic [chunkWidth-1:0] b_q   [numChunks];
  logic [chunkWidth-1:0] b_d   [numChunks];
  logic [chunkWidth-1:0] res_q [numChunks];
  logic [chunkWidth-1:0] res_d [numChunks];

  logic [W-1:0]          b_eff;
  logic                  carry_in_eff;
  logic [chunkWidth-1:0] a_in [numChunks];
  logic [chunkWidth-1:0] b_in [numChunks];
  logic [chunkWidth:0]   rca_full;

`ifdef RCA_SEQ_SUB_EN
  // Subtraction as a + ~b + 1; the final carry is then the "no borrow" flag.
  assign b_eff        = sub ? ~b : b;
  assign carry_in_eff = sub ? 1'b1 : ci;
`else
  assign b_eff        = b;
  assign carry_in_eff = ci;
`endif

  for (genvar g = 0; g < numChunks; g++) begin : g_chunk
    assign a_in[g] = a[g*chunkWidth +: chunkWidth];
    assign b_in[g] = b_eff[g*chunkWidth +: chunkWidth];
    assign s[g*chunkWidth +: chunkWidth] = res_q[g];
  end

  // The single shared narrow adder.
  assign rca_full = {1'b0, a_q[cnt_q]} + {1'b0, b_q[cnt_q]} + {{chunkWidth{1'b0}}, carry_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    co_d    = co_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = carry_in_eff;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d[cnt_q] = rca_full[chunkWidth-1:0];
        carry_d      = rca_full[chunkWidth];
        if (cnt_q == LAST_CNT) begin
          co_d    = rca_full[chunkWidth];
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      for (int i = 0; i < numChunks; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        res_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign co        = co_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Self-checking bench for rca_seq_ctrl (default 32x4 = 128-bit); define RCA_SEQ_SUB_EN to also exercise subtraction.
module tb_rca_seq_ctrl;
  localparam int CW = 32;
  localparam int NC = 4;
  localparam int W  = CW * NC;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ci = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] s;
  logic         co;
  logic         busy;

  logic [W:0]   exp_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  rca_seq_ctrl #(.chunkWidth(CW), .numChunks(NC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci),
`ifdef RCA_SEQ_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .co(co), .busy(busy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: present an operand pair and hold in_valid until it is accepted (bounded).
  task automatic issue_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic civ,
                          input logic subv, output logic ok);
    logic fire;
    a = av; b = bv; ci = civ; sub = subv; in_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      fire = in_ready;
      step();
      if (fire) begin ok = 1'b1; break; end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b exp 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (s !== '0) $display("FAIL reset_s: got %h exp 0", s); else n_pass++;
    n_checks++; if (co !== 1'b0) $display("FAIL reset_co: got %b exp 0", co); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_carry_chain();
    logic ok; int lat; logic [W:0] exp;
    issue_op(128'h1, 128'hFFFF_FFFF, 1'b0, 1'b0, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL carry_accept: got %b exp 1", ok); else n_pass++;
    exp_q.push_back({1'b0, 128'h1_0000_0000});
    n_checks++; if ({busy, in_ready, out_valid} !== 3'b100) $display("FAIL carry_run_flags: got %b exp 100", {busy, in_ready, out_valid}); else n_pass++;
    // Operand bus changes after the handshake must not matter.
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    wait_out_valid(lat);
    n_checks++; if (lat != NC) $display("FAIL carry_latency: got %0d exp %0d", lat, NC); else n_pass++;
    exp = exp_q.pop_front();
    n_checks++; if ({co, s} !== exp) $display("FAIL carry_result: got %h exp %h", {co, s}, exp); else n_pass++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++; if ({busy, in_ready, out_valid} !== 3'b010) $display("FAIL carry_idle_flags: got %b exp 010", {busy, in_ready, out_valid}); else n_pass++;
  endtask

  task automatic test_all_ones();
    logic ok; int lat; logic [W:0] exp;
    issue_op('1, '1, 1'b1, 1'b0, ok);
    exp_q.push_back({1'b1, {W{1'b1}}});
    wait_out_valid(lat);
    n_checks++; if (lat != NC) $display("FAIL ones_latency: got %0d exp %0d", lat, NC); else n_pass++;
    exp = exp_q.pop_front();
    n_checks++; if ({co, s} !== exp) $display("FAIL ones_result: got %h exp %h", {co, s}, exp); else n_pass++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic ok; int lat; logic [W:0] exp; int bad;
    issue_op(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128'hF000_0000_0000_0000_0000_0000_0000_0001, 1'b1, 1'b0, ok);
    exp_q.push_back({1'b0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210}
                    + {1'b0, 128'hF000_0000_0000_0000_0000_0000_0000_0001} + 129'd1);
    wait_out_valid(lat);
    exp = exp_q.pop_front();
    // A second op is offered while the result is held back.
    a = 128'h5; b = 128'h5; ci = 1'b0; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {co, s} !== exp) bad++;
      step();
    end
    n_checks++; if (bad != 0) $display("FAIL stall_hold: got %0d bad cycles exp 0", bad); else n_pass++;
    n_checks++; if ({co, s} !== exp) $display("FAIL stall_result: got %h exp %h", {co, s}, exp); else n_pass++;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL stall_release: got %b exp 10", {in_ready, out_valid}); else n_pass++;
    step(); step();
    n_checks++; if (busy !== 1'b0) $display("FAIL stall_no_accept: got busy %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic ok; int lat; logic [W:0] exp;
    issue_op({W{1'b1}}, 128'h3, 1'b0, 1'b0, ok);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL rstmid_flags: got %b exp 10", {in_ready, out_valid}); else n_pass++;
    n_checks++; if (s !== '0) $display("FAIL rstmid_s: got %h exp 0", s); else n_pass++;
    issue_op(128'd5, 128'd7, 1'b0, 1'b0, ok);
    exp_q.push_back({1'b0, 128'd12});
    wait_out_valid(lat);
    n_checks++; if (lat != NC) $display("FAIL rstmid_latency: got %0d exp %0d", lat, NC); else n_pass++;
    exp = exp_q.pop_front();
    n_checks++; if ({co, s} !== exp) $display("FAIL rstmid_result: got %h exp %h", {co, s}, exp); else n_pass++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

`ifdef RCA_SEQ_SUB_EN
  task automatic test_sub();
    logic ok; int lat; logic [W:0] exp;
    issue_op(128'd3, 128'd5, 1'b0, 1'b1, ok);
    exp_q.push_back({1'b0, {{(W-1){1'b1}}, 1'b0}});
    wait_out_valid(lat);
    exp = exp_q.pop_front();
    n_checks++; if ({co, s} !== exp) $display("FAIL sub_3_minus_5: got %h exp %h", {co, s}, exp); else n_pass++;
    out_ready = 1'b1; step(); out_ready = 1'b0;
    issue_op(128'd5, 128'd3, 1'b1, 1'b1, ok);
    exp_q.push_back({1'b1, 128'd2});
    wait_out_valid(lat);
    exp = exp_q.pop_front();
    n_checks++; if ({co, s} !== exp) $display("FAIL sub_5_minus_3: got %h exp %h", {co, s}, exp); else n_pass++;
    out_ready = 1'b1; step(); out_ready = 1'b0;
    sub = 1'b0;
  endtask
`endif

  task automatic test_back_to_back();
    int issued = 0, received = 0, cyc = 0, bad_hold = 0, empty_pop = 0, bad_res = 0;
    logic in_fire, out_fire, hold;
    logic [W:0] exp, held;
    in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0;
    while (received < 100 && cyc < 20000) begin
      if (!in_valid && issued < 100 && $urandom_range(0, 3) != 0) begin
        a  = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom, $urandom, $urandom};
        b  = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom, $urandom, $urandom};
        ci = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      hold     = out_valid && !out_ready;
      held     = {co, s};
      if (in_fire) begin
        exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci});
        issued++;
      end
      if (out_fire) begin
        if (exp_q.size() == 0) empty_pop++;
        else begin
          exp = exp_q.pop_front();
          if ({co, s} !== exp) begin
            bad_res++;
            $display("FAIL b2b_result #%0d: got %h exp %h", received, {co, s}, exp);
          end
        end
      end
      step();
      cyc++;
      if (in_fire) in_valid = 1'b0;
      if (out_fire) received++;
      if (hold && (out_valid !== 1'b1 || {co, s} !== held)) bad_hold++;
    end
    out_ready = 1'b0;
    n_checks++; if (bad_res != 0) $display("FAIL b2b_mismatches: got %0d exp 0", bad_res); else n_pass++;
    n_checks++; if (received != 100) $display("FAIL b2b_received: got %0d exp 100", received); else n_pass++;
    n_checks++; if (empty_pop != 0) $display("FAIL b2b_extra_results: got %0d exp 0", empty_pop); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL b2b_pending: got %0d exp 0", exp_q.size()); else n_pass++;
    n_checks++; if (bad_hold != 0) $display("FAIL b2b_hold_stable: got %0d exp 0", bad_hold); else n_pass++;
    step(); step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_duplicate: got out_valid %b exp 0", out_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_all_ones();
    test_stall();
    test_reset_mid();
`ifdef RCA_SEQ_SUB_EN
    test_sub();
`endif
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
